pipe_hazard_ctrl: RTL

Parametrised pipeline control unit for the in-order RISC-V core. It generalises the load-use stall and branch flush handling to N stages and adds per-stage valid tracking, multi-cycle load-use stalls, data-memory wait stalls and saturating stall/flush performance counters. It sits beside the stage modules in the cpu top and drives every pipeline-register enable and flush, plus pc_write.

---
 rtl/common_pkg.sv | 19 +
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared definitions for the pipeline control unit: hazard cause encoding
// and fixed stage indices.
package common;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_BRANCH,
    HZ_MEM_WAIT
  } hazard_cause_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;

  // Load-use hold length is at most 7 cycles, so 3 bits always suffice.
  localparam int LU_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                    cnt_d = '0;
    else if (inc && ~&cnt_q)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: per-stage enables/flushes, valid tracking, load-use and
// memory-wait stalls, branch flushes, and saturating stall/flush counters.
module pipe_hazard_ctrl
  import common::*;
#(
  parameter int NUM_STAGES      = 5,
  parameter int REG_ADDR_W      = 5,
  parameter int BRANCH_STAGE    = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  pc_write,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WB = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic                  started_q;
  logic [LU_CNT_W-1:0]   luc_q, luc_d;
  logic                  load_use, br;
  hazard_cause_t         cause;

  always_comb begin
    load_use = v_q[STG_ID] & v_q[STG_EX] & ex_mem_read & (ex_rd != '0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    br       = v_q[BRANCH_STAGE] & branch_taken;

    if (mem_busy)                      cause = HZ_MEM_WAIT;
    else if (br)                       cause = HZ_BRANCH;
    else if (load_use || luc_q != '0)  cause = HZ_LOAD_USE;
    else                               cause = HZ_NONE;
  end

  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    pc_write    = started_q;
    luc_d       = luc_q;
    unique case (cause)
      HZ_MEM_WAIT: begin
        // Everything up to MEM freezes; WB drains with a bubble.
        stage_en        = '0;
        stage_en[WB]    = 1'b1;
        stage_flush[WB] = 1'b1;
        pc_write        = 1'b0;
      end
      HZ_BRANCH: begin
        for (int i = STG_ID; i <= BRANCH_STAGE; i++) stage_flush[i] = 1'b1;
        pc_write = 1'b1;
        luc_d    = '0;
      end
      HZ_LOAD_USE: begin
        stage_en[STG_IF]    = 1'b0;
        stage_en[STG_ID]    = 1'b0;
        stage_flush[STG_EX] = 1'b1;
        pc_write            = 1'b0;
        luc_d = (luc_q != '0) ? luc_q - 1'b1 : LU_CNT_W'(LOAD_USE_CYCLES - 1);
      end
      default: ;
    endcase
    if (!reset_n) begin
      stage_en    = '0;
      stage_flush = '1;
      pc_write    = 1'b0;
    end
  end

  // Valid bits follow the data: bubble on flush, shift on enable, else hold.
  always_comb begin
    v_d = v_q;
    if (stage_flush[0])   v_d[0] = 1'b0;
    else if (stage_en[0]) v_d[0] = started_q;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (stage_flush[i])   v_d[i] = 1'b0;
      else if (stage_en[i]) v_d[i] = v_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q       <= '0;
      started_q <= 1'b0;
      luc_q     <= '0;
    end else begin
      v_q       <= v_d;
      started_q <= 1'b1;
      luc_q     <= luc_d;
    end
  end

  assign stage_valid = v_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((cause == HZ_MEM_WAIT) || (cause == HZ_LOAD_USE)),
    .clear   (1'b0),
    .cnt     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cause == HZ_BRANCH),
    .clear   (1'b0),
    .cnt     (flush_cnt)
  );

endmodule
